rep_encoder: RTL

- Transmit-side counterpart of the 5-input majority decoder: a repetition-code encoder.
- Accepts parallel data words over a valid/ready handshake.
- Serialises each word LSB-first, emitting every data bit REP consecutive times on a valid/ready bit stream.
- Downstream, a majority voter over each group of REP copies recovers the bit. An optional per-word corruption mask lets benches exercise decoder error tolerance.

---
 rtl/rep_pkg.sv | 17 +
 rtl/rep_beat_counter.sv | 47 ++++
 rtl/rep_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/rep_pkg.sv
// Shared types, default sizes and a width helper for the repetition-code encoder.
package rep_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REP    = 5;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rep_beat_counter.sv
// Nested copy/bit counter for the encoder: rep_cnt runs fastest, bit_cnt
// advances when a group of REP copies completes.
module rep_beat_counter
  import rep_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REP    = DEF_REP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  output logic [clog2_min1(REP)-1:0]    rep_cnt,
  output logic [clog2_min1(DATA_W)-1:0] bit_cnt,
  output logic                          first,
  output logic                          group_end,
  output logic                          last
);

  localparam int RCW = clog2_min1(REP);
  localparam int BCW = clog2_min1(DATA_W);
  localparam logic [RCW-1:0] REP_MAX = RCW'(REP - 1);
  localparam logic [BCW-1:0] BIT_MAX = BCW'(DATA_W - 1);

  // Clear wins over enable so a reload on the final beat restarts at copy 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (rep_cnt == REP_MAX) begin
        rep_cnt <= '0;
        bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign first     = (rep_cnt == '0);
  assign group_end = (rep_cnt == REP_MAX);
  assign last      = group_end && (bit_cnt == BIT_MAX);

endmodule

// File: rtl/rep_encoder.sv
// Repetition-code encoder: serialises each word LSB-first, REP copies per bit,
// with an optional per-copy inversion mask for exercising the decoder.
module rep_encoder
  import rep_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REP    = DEF_REP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REP-1:0]    in_mask,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_first,
  output logic              tx_last,
  output logic              busy
);

  localparam int RCW = clog2_min1(REP);
  localparam int BCW = clog2_min1(DATA_W);

  if (REP < 3 || (REP % 2) == 0) begin : g_bad_rep
    $fatal(1, "rep_encoder: REP must be odd and >= 3");
  end
  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "rep_encoder: DATA_W must be >= 1");
  end

  state_t            state, state_next;
  logic [DATA_W-1:0] shift_q;
  logic [REP-1:0]    mask_q;
  logic [RCW-1:0]    rep_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic              cnt_first, cnt_group_end, cnt_last;
  logic              accept, beat, sending, mask_bit;

  assign sending  = (state == SEND);
  assign tx_valid = sending;
  assign busy     = sending;
  assign tx_first = sending && cnt_first;
  assign tx_last  = sending && cnt_last;
  assign in_ready = (state == IDLE) || (tx_last && tx_ready);
  assign accept   = in_valid && in_ready;
  assign beat     = tx_valid && tx_ready;

  rep_beat_counter #(
    .DATA_W (DATA_W),
    .REP    (REP)
  ) u_beat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept),
    .en        (beat),
    .rep_cnt   (rep_cnt),
    .bit_cnt   (bit_cnt),
    .first     (cnt_first),
    .group_end (cnt_group_end),
    .last      (cnt_last)
  );

  always_comb begin
    mask_bit = 1'b0;
    for (int k = 0; k < REP; k++) begin
      if (rep_cnt == RCW'(k)) mask_bit = mask_q[k];
    end
  end

  assign tx_bit = sending && (shift_q[0] ^ mask_bit);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SEND;
      SEND: if (beat && tx_last) state_next = accept ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The word shifts only once all REP copies of the current bit have gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      mask_q  <= '0;
    end else if (accept) begin
      shift_q <= in_data;
      mask_q  <= in_mask;
    end else if (beat && cnt_group_end) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule
